// File: rtl/goertzel_pkg.sv
// Shared definitions for the Goertzel frame detector: state encoding and
// default widths used by the detector top and its hysteresis sub-block.
package goertzel_pkg;

    localparam int unsigned MAG_W_DEF       = 16;
    localparam int unsigned RUN_BITS_DEF    = 5;
    localparam int unsigned HOLD_FRAMES_DEF = 4;

    localparam int unsigned STATE_W = 2;

    // Frame FSM states
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_ACCUM = 2'd1;
    localparam logic [STATE_W-1:0] ST_EVAL  = 2'd2;

endpackage

// File: rtl/mag_hysteresis.sv
// On/off hysteresis with hold-off counter for the frame detector.
// Ports:
//   sys_clk, rst_n          clock, async active-low reset
//   eval_en                 high for the single EVAL cycle of a frame
//   peak, peak_bin          peak magnitude / bin of the frame being evaluated
//   thresh_on, thresh_off   assert (strict >) and sustain (>=) thresholds
//   detect, detect_bin      registered detection level and its bin index
module mag_hysteresis
    import goertzel_pkg::*;
#(
    parameter int unsigned MAG_W       = MAG_W_DEF,
    parameter int unsigned RUN_BITS    = RUN_BITS_DEF,
    parameter int unsigned HOLD_FRAMES = HOLD_FRAMES_DEF
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                eval_en,
    input  logic [MAG_W-1:0]    peak,
    input  logic [RUN_BITS-1:0] peak_bin,
    input  logic [MAG_W-1:0]    thresh_on,
    input  logic [MAG_W-1:0]    thresh_off,
    output logic                detect,
    output logic [RUN_BITS-1:0] detect_bin
);

    localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    logic [HOLD_W-1:0]   hold_ctr;
    logic [HOLD_W-1:0]   hold_nxt;
    logic                detect_nxt;
    logic [RUN_BITS-1:0] bin_nxt;

    // Next detect state; only a frame evaluation may move it
    always_comb begin
        detect_nxt = detect;
        hold_nxt   = hold_ctr;
        bin_nxt    = detect_bin;
        if (eval_en) begin
            if (!detect) begin
                if (peak > thresh_on) begin
                    detect_nxt = 1'b1;
                    bin_nxt    = peak_bin;
                    hold_nxt   = '0;
                end
            end else if (peak >= thresh_off) begin
                hold_nxt = '0;
                bin_nxt  = peak_bin;
            end else if (hold_ctr == HOLD_LAST) begin
                detect_nxt = 1'b0;
                hold_nxt   = '0;
            end else begin
                hold_nxt = hold_ctr + HOLD_W'(1);
            end
        end
    end

    // Detect state registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            detect     <= 1'b0;
            detect_bin <= '0;
            hold_ctr   <= '0;
        end else begin
            detect     <= detect_nxt;
            detect_bin <= bin_nxt;
            hold_ctr   <= hold_nxt;
        end
    end

endmodule

// File: rtl/goertzel_mag_detector.sv
// Frame-level magnitude detector behind the Goertzel manager: finds the peak
// bin and total energy per frame of num_runs bins, then applies hysteresis.
// Ports:
//   sys_clk, rst_n              clock, async active-low reset
//   mag_in, mag_rdy             per-bin magnitude and its one-cycle strobe
//   num_runs                    bins per frame, sampled at each frame start
//   thresh_on, thresh_off       hysteresis thresholds (used in EVAL)
//   peak_mag, peak_bin          peak of the last completed frame
//   total_energy                sum of all bins of the last completed frame
//   frame_done                  one-cycle pulse when frame outputs update
//   detect, detect_bin          hysteretic detection level and bin
module goertzel_mag_detector
    import goertzel_pkg::*;
#(
    parameter int unsigned MAG_W       = MAG_W_DEF,
    parameter int unsigned RUN_BITS    = RUN_BITS_DEF,
    parameter int unsigned HOLD_FRAMES = HOLD_FRAMES_DEF
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic [MAG_W-1:0]          mag_in,
    input  logic                      mag_rdy,
    input  logic [RUN_BITS-1:0]       num_runs,
    input  logic [MAG_W-1:0]          thresh_on,
    input  logic [MAG_W-1:0]          thresh_off,
    output logic [MAG_W-1:0]          peak_mag,
    output logic [RUN_BITS-1:0]       peak_bin,
    output logic [MAG_W+RUN_BITS-1:0] total_energy,
    output logic                      frame_done,
    output logic                      detect,
    output logic [RUN_BITS-1:0]       detect_bin
);

    localparam int unsigned ACC_W = MAG_W + RUN_BITS;

    logic [STATE_W-1:0]  state;
    logic [STATE_W-1:0]  state_nxt;
    logic                in_eval;
    logic                frame_start;
    logic                bin_accum;
    logic [RUN_BITS-1:0] frames_len;
    logic [RUN_BITS-1:0] bin_ctr;
    logic [RUN_BITS-1:0] bin_ctr_inc;
    logic [RUN_BITS-1:0] cur_bin;
    logic [MAG_W-1:0]    cur_peak;
    logic [ACC_W-1:0]    acc;

    // EVAL accepts a new frame's bin 0 exactly like IDLE so no strobe is lost
    assign in_eval     = (state == ST_EVAL);
    assign frame_start = mag_rdy && (num_runs != '0) && ((state == ST_IDLE) || in_eval);
    assign bin_accum   = mag_rdy && (state == ST_ACCUM);
    assign bin_ctr_inc = bin_ctr + RUN_BITS'(1);

    // State register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_EVAL: begin
                if (frame_start) begin
                    state_nxt = (num_runs == RUN_BITS'(1)) ? ST_EVAL : ST_ACCUM;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (bin_accum && (bin_ctr_inc == frames_len)) begin
                    state_nxt = ST_EVAL;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Peak search and energy accumulation; strict > keeps the lowest bin on ties
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_len <= '0;
            bin_ctr    <= '0;
            cur_bin    <= '0;
            cur_peak   <= '0;
            acc        <= '0;
        end else if (frame_start) begin
            frames_len <= num_runs;
            bin_ctr    <= RUN_BITS'(1);
            cur_bin    <= '0;
            cur_peak   <= mag_in;
            acc        <= ACC_W'(mag_in);
        end else if (bin_accum) begin
            bin_ctr <= bin_ctr_inc;
            acc     <= acc + ACC_W'(mag_in);
            if (mag_in > cur_peak) begin
                cur_peak <= mag_in;
                cur_bin  <= bin_ctr;
            end
        end
    end

    // Frame result registers, loaded during EVAL
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_mag     <= '0;
            peak_bin     <= '0;
            total_energy <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= in_eval;
            if (in_eval) begin
                peak_mag     <= cur_peak;
                peak_bin     <= cur_bin;
                total_energy <= acc;
            end
        end
    end

    mag_hysteresis #(
        .MAG_W       (MAG_W),
        .RUN_BITS    (RUN_BITS),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_hyst (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .eval_en    (in_eval),
        .peak       (cur_peak),
        .peak_bin   (cur_bin),
        .thresh_on  (thresh_on),
        .thresh_off (thresh_off),
        .detect     (detect),
        .detect_bin (detect_bin)
    );

endmodule

// File: tb/tb_goertzel_mag_detector.sv
// Bench for goertzel_mag_detector: directed literal checks followed by
// randomized traffic compared each cycle against a frame-level model.
module tb_goertzel_mag_detector;

    localparam int unsigned HOLD = 4;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b1;
    logic [15:0] mag_in  = '0;
    logic        mag_rdy = 1'b0;
    logic [4:0]  num_runs = '0;
    logic [15:0] thresh_on  = 16'hFFFF;
    logic [15:0] thresh_off = 16'hFFFF;
    logic [15:0] peak_mag;
    logic [4:0]  peak_bin;
    logic [20:0] total_energy;
    logic        frame_done;
    logic        detect;
    logic [4:0]  detect_bin;

    int n_pass  = 0;
    int n_total = 0;

    goertzel_mag_detector #(
        .MAG_W       (16),
        .RUN_BITS    (5),
        .HOLD_FRAMES (HOLD)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .mag_in       (mag_in),
        .mag_rdy      (mag_rdy),
        .num_runs     (num_runs),
        .thresh_on    (thresh_on),
        .thresh_off   (thresh_off),
        .peak_mag     (peak_mag),
        .peak_bin     (peak_bin),
        .total_energy (total_energy),
        .frame_done   (frame_done),
        .detect       (detect),
        .detect_bin   (detect_bin)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- frame-level reference model ----------------
    logic [15:0] m_peak;
    logic [4:0]  m_bin;
    logic [20:0] m_energy;
    logic        m_fd;
    logic        m_det;
    logic [4:0]  m_dbin;
    int          m_hold;
    bit          pend;
    int unsigned p_peak, p_bin, p_sum;
    int unsigned fbins[$];
    int unsigned flen;

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_peak = '0; m_bin = '0; m_energy = '0; m_fd = 1'b0;
            m_det = 1'b0; m_dbin = '0; m_hold = 0;
            pend = 1'b0; fbins.delete(); flen = 0;
        end else begin
            m_fd = 1'b0;
            // A frame completed on the previous edge is published on this one
            if (pend) begin
                m_peak   = 16'(p_peak);
                m_bin    = 5'(p_bin);
                m_energy = 21'(p_sum);
                m_fd     = 1'b1;
                if (!m_det) begin
                    if (p_peak > int'(thresh_on)) begin
                        m_det = 1'b1; m_dbin = 5'(p_bin); m_hold = 0;
                    end
                end else if (p_peak >= int'(thresh_off)) begin
                    m_hold = 0; m_dbin = 5'(p_bin);
                end else begin
                    m_hold++;
                    if (m_hold == HOLD) begin
                        m_det = 1'b0; m_hold = 0;
                    end
                end
                pend = 1'b0;
            end
            if (mag_rdy) begin
                if (fbins.size() == 0) begin
                    if (num_runs != 0) begin
                        flen = num_runs;
                        fbins.push_back(mag_in);
                    end
                end else begin
                    fbins.push_back(mag_in);
                end
                if (fbins.size() != 0 && fbins.size() == flen) begin
                    p_sum = 0;
                    p_peak = 0;
                    p_bin = 0;
                    foreach (fbins[i]) begin
                        p_sum += fbins[i];
                        if (i == 0 || fbins[i] > p_peak) begin
                            p_peak = fbins[i];
                            p_bin  = i;
                        end
                    end
                    pend = 1'b1;
                    fbins.delete();
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge sys_clk) begin
        if (rst_n) begin
            n_total++;
            if (frame_done !== m_fd || peak_mag !== m_peak || peak_bin !== m_bin ||
                total_energy !== m_energy || detect !== m_det || detect_bin !== m_dbin) begin
                $display("FAIL cycle_cmp t=%0t got fd=%0b pk=%0d bin=%0d en=%0d det=%0b dbin=%0d exp fd=%0b pk=%0d bin=%0d en=%0d det=%0b dbin=%0d",
                         $time, frame_done, peak_mag, peak_bin, total_energy, detect, detect_bin,
                         m_fd, m_peak, m_bin, m_energy, m_det, m_dbin);
            end else begin
                n_pass++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input bit rdy, input int unsigned mag, input int unsigned nr);
        @(posedge sys_clk);
        #1;
        mag_rdy  = rdy;
        mag_in   = 16'(mag);
        num_runs = 5'(nr);
    endtask

    // Two-bin frame, then sample on the cycle its results are visible
    task automatic frame2(input int unsigned a, input int unsigned b);
        tick(1'b1, a, 2);
        tick(1'b1, b, 2);
        tick(1'b0, 0, 2);
        tick(1'b0, 0, 2);
        @(negedge sys_clk);
        chk("frame2_done", frame_done, 1);
    endtask

    task automatic chk_det(input string name, input bit d, input int unsigned b);
        chk({name, "_detect"}, detect, d);
        chk({name, "_dbin"}, detect_bin, b);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_peak"}, peak_mag, 0);
        chk({name, "_bin"}, peak_bin, 0);
        chk({name, "_energy"}, total_energy, 0);
        chk({name, "_fd"}, frame_done, 0);
        chk({name, "_detect"}, detect, 0);
        chk({name, "_dbin"}, detect_bin, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int unsigned nr;
        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        repeat (3) @(posedge sys_clk);
        #1 rst_n = 1'b1;

        // Peak with tie: lowest bin wins
        tick(1'b1, 100, 4);
        tick(1'b1, 300, 4);
        tick(1'b1, 300, 4);
        tick(1'b1, 50, 4);
        tick(1'b0, 0, 4);
        @(negedge sys_clk);
        chk("fd_early", frame_done, 0);
        tick(1'b0, 0, 4);
        @(negedge sys_clk);
        chk("fd_on_time", frame_done, 1);
        chk("peak_300", peak_mag, 300);
        chk("peak_bin_1", peak_bin, 1);
        chk("energy_750", total_energy, 750);
        tick(1'b0, 0, 4);
        @(negedge sys_clk);
        chk("fd_pulse_width", frame_done, 0);

        // Hysteresis with hold-off
        thresh_on  = 16'd200;
        thresh_off = 16'd150;
        frame2(10, 250);  chk_det("hy1", 1'b1, 1);
        frame2(5, 160);   chk_det("hy2", 1'b1, 1);
        frame2(100, 0);   chk_det("hy3", 1'b1, 1);
        frame2(100, 0);   chk_det("hy4", 1'b1, 1);
        frame2(100, 0);   chk_det("hy5", 1'b1, 1);
        frame2(100, 0);   chk_det("hy6", 1'b0, 1);

        // Strict assert threshold
        frame2(200, 0);   chk_det("on_eq", 1'b0, 1);
        frame2(0, 201);   chk_det("on_gt", 1'b1, 1);

        // Single-bin frames back to back
        tick(1'b1, 10, 1);
        tick(1'b1, 20, 1);
        tick(1'b1, 30, 1);
        @(negedge sys_clk);
        chk("b2b_fd0", frame_done, 1);
        chk("b2b_pk0", peak_mag, 10);
        tick(1'b0, 0, 1);
        @(negedge sys_clk);
        chk("b2b_fd1", frame_done, 1);
        chk("b2b_pk1", peak_mag, 20);
        tick(1'b0, 0, 1);
        @(negedge sys_clk);
        chk("b2b_fd2", frame_done, 1);
        chk("b2b_pk2", peak_mag, 30);

        // Zero-length frame request is ignored
        tick(1'b1, 999, 0);
        repeat (3) begin
            tick(1'b0, 0, 0);
            @(negedge sys_clk);
            chk("nr0_no_fd", frame_done, 0);
        end

        // num_runs change mid-frame has no effect; fourth sub-off frame drops detect
        tick(1'b1, 1, 3);
        tick(1'b1, 2, 5);
        tick(1'b1, 3, 5);
        tick(1'b0, 0, 5);
        tick(1'b0, 0, 5);
        @(negedge sys_clk);
        chk("len_fd", frame_done, 1);
        chk("len_energy", total_energy, 6);
        chk("len_peak_bin", peak_bin, 2);
        chk("len_detect", detect, 0);

        // Reset mid-frame while detecting
        frame2(0, 250);   chk_det("pre_rst", 1'b1, 1);
        tick(1'b1, 7, 4);
        tick(1'b1, 8, 4);
        @(posedge sys_clk);
        #1;
        mag_rdy = 1'b0;
        rst_n   = 1'b0;
        #1 chk_zero("mid_rst");
        @(posedge sys_clk);
        #1 rst_n = 1'b1;
        tick(1'b1, 4, 4);
        tick(1'b1, 9, 4);
        tick(1'b1, 9, 4);
        tick(1'b1, 2, 4);
        tick(1'b0, 0, 4);
        tick(1'b0, 0, 4);
        @(negedge sys_clk);
        chk("post_rst_fd", frame_done, 1);
        chk("post_rst_peak", peak_mag, 9);
        chk("post_rst_bin", peak_bin, 1);
        chk("post_rst_energy", total_energy, 24);

        // Randomized traffic against the model
        nr = 3;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                thresh_on  = 16'($urandom_range(400, 700));
                thresh_off = 16'($urandom_range(200, 450));
            end
            if ($urandom_range(0, 99) < 10) begin
                nr = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            end
            tick($urandom_range(0, 99) < 70, $urandom_range(0, 1000), nr);
        end
        repeat (10) tick(1'b0, 0, nr);
        @(negedge sys_clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
